// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared state encoding and default sizing for the datapath loader
package datapath_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_DEPTH  = 32;
    localparam int DEF_RAM_DEPTH  = 32;
    localparam int DEF_RUN_CYCLES = 75;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD_RF  = 3'd1;
    localparam state_t ST_LOAD_RAM = 3'd2;
    localparam state_t ST_RUN      = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

endpackage

// File: rtl/datapath_loader_run_timer.sv
// rtl/datapath_loader_run_timer.sv - saturating RUN cycle counter with terminal-count flag
module datapath_loader_run_timer #(
    parameter int RUN_CYCLES = 75,
    parameter int CW         = $clog2(RUN_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] TERM = CW'(RUN_CYCLES);

    // Holds at TERM so the DONE state reports the exact run length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != TERM)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/datapath_loader.sv
// rtl/datapath_loader.sv - image preload and fixed-length run sequencer for the MIPS datapath; optional DATAPATH_LOADER_CHECKSUM_EN
module datapath_loader
    import datapath_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_DEPTH  = DEF_REG_DEPTH,
    parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic                                   src_rd,
    output logic [$clog2(REG_DEPTH+RAM_DEPTH)-1:0] src_addr,
    input  logic [DATA_W-1:0]                      src_data,
    input  logic                                   src_valid,
    output logic                                   rf_we,
    output logic [$clog2(REG_DEPTH)-1:0]           rf_addr,
    output logic [DATA_W-1:0]                      rf_wdata,
    output logic                                   ram_we,
    output logic [$clog2(RAM_DEPTH)-1:0]           ram_addr,
    output logic [DATA_W-1:0]                      ram_wdata,
    output logic                                   dp_reset,
    output logic                                   busy,
    output logic                                   done,
`ifdef DATAPATH_LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0]                      load_csum,
    input  logic [DATA_W-1:0]                      exp_csum,
    output logic                                   csum_err,
`endif
    output logic [$clog2(RUN_CYCLES+1)-1:0]        cycle_count
);

    localparam int SRC_AW = $clog2(REG_DEPTH + RAM_DEPTH);
    localparam int RF_AW  = $clog2(REG_DEPTH);
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int CW     = $clog2(RUN_CYCLES + 1);

    localparam logic [SRC_AW-1:0] LAST_RF  = SRC_AW'(REG_DEPTH - 1);
    localparam logic [SRC_AW-1:0] LAST_IDX = SRC_AW'(REG_DEPTH + RAM_DEPTH - 1);
    localparam logic [SRC_AW-1:0] RAM_BASE = SRC_AW'(REG_DEPTH);

    state_t state;
    logic   take;
    logic   start_ok;
    logic   run_tc;
    logic   csum_ok;

    assign take     = src_rd && src_valid;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef DATAPATH_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_next;

    assign csum_next = load_csum ^ src_data;
    assign csum_ok   = (csum_next == exp_csum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_csum <= '0;
            csum_err  <= 1'b0;
        end else if (start_ok) begin
            load_csum <= '0;
            csum_err  <= 1'b0;
        end else if (take) begin
            load_csum <= csum_next;
            if ((state == ST_LOAD_RAM) && (src_addr == LAST_IDX) && !csum_ok) begin
                csum_err <= 1'b1;
            end
        end
    end
`else
    assign csum_ok = 1'b1;
`endif

    datapath_loader_run_timer #(
        .RUN_CYCLES (RUN_CYCLES),
        .CW         (CW)
    ) u_run_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (state == ST_RUN),
        .count (cycle_count),
        .tc    (run_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            src_rd    <= 1'b0;
            src_addr  <= '0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            dp_reset  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rf_we  <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD_RF;
                        src_rd   <= 1'b1;
                        src_addr <= '0;
                        dp_reset <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                ST_LOAD_RF: begin
                    if (take) begin
                        rf_we    <= 1'b1;
                        rf_addr  <= RF_AW'(src_addr);
                        rf_wdata <= src_data;
                        src_addr <= src_addr + 1'b1;
                        if (src_addr == LAST_RF) begin
                            state <= ST_LOAD_RAM;
                        end
                    end
                end
                ST_LOAD_RAM: begin
                    if (take) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= RAM_AW'(src_addr - RAM_BASE);
                        ram_wdata <= src_data;
                        src_addr  <= src_addr + 1'b1;
                        if (src_addr == LAST_IDX) begin
                            src_rd <= 1'b0;
                            // A bad image never releases the datapath.
                            if (csum_ok) begin
                                state <= ST_RUN;
                            end else begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (run_tc) begin
                        state    <= ST_DONE;
                        dp_reset <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        dp_reset <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_loader.sv
// tb/tb_datapath_loader.sv - self-checking bench for datapath_loader with an image-level reference model
module tb_datapath_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        src_rd;
    logic [5:0]  src_addr;
    logic [31:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        dp_reset;
    logic        busy;
    logic        done;
    logic [6:0]  cycle_count;
`ifdef DATAPATH_LOADER_CHECKSUM_EN
    logic [31:0] load_csum;
    logic [31:0] exp_csum = '0;
    logic        csum_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] img [64];

    datapath_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_rd      (src_rd),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .dp_reset    (dp_reset),
        .busy        (busy),
        .done        (done),
`ifdef DATAPATH_LOADER_CHECKSUM_EN
        .load_csum   (load_csum),
        .exp_csum    (exp_csum),
        .csum_err    (csum_err),
`endif
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int k = 0; k < 64; k++) begin
            if (kind == 0)      img[k] = 32'(k + 100);
            else if (kind == 2) img[k] = 32'(k + 1);
            else                img[k] = $urandom;
        end
    endtask

    function automatic logic [31:0] img_xor();
        logic [31:0] x = '0;
        for (int k = 0; k < 64; k++) x ^= img[k];
        return x;
    endfunction

    task automatic set_exp();
`ifdef DATAPATH_LOADER_CHECKSUM_EN
        exp_csum = img_xor();
`endif
    endtask

    // vmode 0: source always valid; 1: valid every third cycle.
    task automatic do_run(input int vmode, input bit poke_start, input bit expect_run);
        int rf_n = 0, ram_n = 0, errs_rf = 0, errs_ram = 0, overlap = 0, unstable = 0;
        int first_we = -1, last_we = -1, dp_fall = -1, done_n = -1, dp_low = 0, vcnt = 0;
        bit poked = 0, prev_wait = 0;
        logic [5:0] prev_addr = '0;
        @(negedge clk);
        start = 1'b1;
        src_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_state", {src_rd, src_addr == 6'd0, done, dp_reset, busy}, 5'b11011);
        for (int n = 0; n < 1000; n++) begin
            if (rf_we) begin
                if (rf_addr != 5'(rf_n) || rf_wdata != img[rf_n]) errs_rf++;
                rf_n++;
            end
            if (ram_we) begin
                if (ram_addr != 5'(ram_n) || ram_wdata != img[32 + ram_n]) errs_ram++;
                ram_n++;
            end
            if (rf_we && ram_we) overlap++;
            if (rf_we || ram_we) begin
                if (first_we < 0) first_we = n;
                last_we = n;
            end
            if (prev_wait && src_addr != prev_addr) unstable++;
            if (!dp_reset) begin
                dp_low++;
                if (dp_fall < 0) dp_fall = n;
            end
            if (done) begin
                done_n = n;
                break;
            end
            start = 1'b0;
            if (poke_start && !poked && cycle_count == 7'd10) begin
                start = 1'b1;
                poked = 1;
            end
            vcnt++;
            src_valid = (vmode == 0) ? 1'b1 : (vcnt % 3 == 0);
            src_data  = src_valid ? img[src_addr] : $urandom;
            prev_wait = src_rd && !src_valid;
            prev_addr = src_addr;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_reached", done_n >= 0, 1);
        chk("rf_count", rf_n, 32);
        chk("rf_content_errs", errs_rf, 0);
        chk("ram_count", ram_n, 32);
        chk("ram_content_errs", errs_ram, 0);
        chk("strobe_overlap", overlap, 0);
        chk("addr_unstable", unstable, 0);
        if (vmode == 0) chk("load_span", last_we - first_we, 63);
        if (poke_start) chk("poke_seen", poked, 1);
        if (expect_run) begin
            chk("dp_fall_after_last_we", dp_fall, last_we + 1);
            chk("run_length", done_n - dp_fall, 75);
            chk("dp_low_clocks", dp_low, 75);
            chk("final_count", cycle_count, 75);
        end else begin
            chk("abort_dp_low", dp_low, 0);
            chk("abort_count", cycle_count, 0);
            chk("abort_done_time", done_n, last_we);
        end
        chk("done_outputs", {dp_reset, busy, src_rd}, 3'b100);
`ifdef DATAPATH_LOADER_CHECKSUM_EN
        chk("load_csum", load_csum, img_xor());
        chk("csum_err", csum_err, !expect_run);
`endif
    endtask

    initial begin
        bit found = 0;
        fill(0);
        repeat (3) @(negedge clk);
        chk("reset_flags", {src_rd, rf_we, ram_we, busy, done, dp_reset}, 6'b000001);
        chk("reset_addrs", {src_addr, rf_addr, ram_addr}, 16'd0);
        chk("reset_count", cycle_count, 0);
        reset = 1'b1;

        set_exp();
        do_run(0, 0, 1);

        fill(1);
        set_exp();
        do_run(1, 0, 1);

        fill(1);
        set_exp();
        do_run(0, 1, 1);

        // Asynchronous abort in the middle of the RAM load.
        fill(1);
        set_exp();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ram_we && ram_addr == 5'd7) begin
                found = 1;
                break;
            end
            src_valid = 1'b1;
            src_data  = img[src_addr];
            @(negedge clk);
        end
        chk("reach_ram7", found, 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_flags", {src_rd, rf_we, ram_we, busy, done, dp_reset}, 6'b000001);
        chk("abort_addrs", {src_addr, rf_addr, ram_addr}, 16'd0);
        chk("abort_wdata", rf_wdata | ram_wdata, 0);
        chk("abort_cycle_count", cycle_count, 0);
        #1 reset = 1'b1;
        do_run(1, 0, 1);

        do_run(0, 0, 1);

`ifdef DATAPATH_LOADER_CHECKSUM_EN
        fill(2);
        exp_csum = 32'd64;
        do_run(0, 0, 1);
        exp_csum = 32'd0;
        do_run(0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
